mult_accum: RTL and testbench
=============================

Name: mult_accum

Overview:
- Sequential accumulator placed directly downstream of the combinational `mult` block.
- Consumes a stream of WIDTH-bit products on a valid/ready handshake and sums exactly NUM_TERMS of them.
- Presents each sum on a registered valid/ready output port.
- Typical use: the dot-product / MAC stage fed by `mult.out`.

Parameters:
- WIDTH, 32, width of each incoming product; matches `mult` WIDTH.
- NUM_TERMS, 4, number of products summed per result; legal range 1..256.
- ACC_WIDTH, WIDTH+$clog2(NUM_TERMS)+1, localparam, derived and not overridable; accumulator and result width, wide enough that no overflow is possible.

Ports:
- clk  input  1  system clock; only clock in the block; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous abort: discard partial sum and any pending result.
- in_valid  input  1  product present on in_data.
- in_ready  output  1  block can accept a product this cycle.
- in_data  input  WIDTH  unsigned product from `mult`.
- out_valid  output  1  out_sum holds a completed result.
- out_ready  input  1  downstream accepts out_sum this cycle.
- out_sum  output  ACC_WIDTH  completed sum of NUM_TERMS products, unsigned.
- term_cnt  output  8  number of products accepted into the current partial sum (debug/status).

Behaviour:
- Reset (rst_n low, asynchronous, effective immediately without a clock edge):
  - state = ACC, acc = 0, term_cnt = 0, out_sum = 0, out_valid = 0.
  - in_ready = 1 on the first edge after release.
- FSM, two states, ACC and HOLD:
  - ACC: in_ready = 1, out_valid = 0.
  - HOLD: in_ready = 0, out_valid = 1.
- Accept rule: a transfer occurs when in_valid & in_ready are both high on a rising edge.
- On accept in ACC when term_cnt < NUM_TERMS-1:
  - acc <= acc + zero_extend(in_data); term_cnt <= term_cnt + 1.
- On accept in ACC when term_cnt == NUM_TERMS-1:
  - out_sum <= acc + zero_extend(in_data); acc <= 0; term_cnt <= 0; state <= HOLD.
  - out_valid asserts in the cycle after the last accept (latency 1).
- HOLD:
  - out_sum and out_valid stay stable until out_ready is high on an edge; then state <= ACC and out_valid <= 0.
  - in_ready returns to 1 in the following cycle. There is no accept during the output handshake cycle, so the sustained rate is NUM_TERMS+1 cycles per result.
- in_valid low cycles (bubbles) in ACC: acc and term_cnt hold.
- NUM_TERMS = 1: every accept goes straight to HOLD.
- clear (synchronous, highest priority after rst_n):
  - acc <= 0; term_cnt <= 0; state <= ACC; out_valid <= 0.
  - out_sum keeps its old value; it is don't-care while out_valid is low.
  - Any product presented in the same cycle as clear is dropped. in_ready may still read 1 that cycle, but the beat is discarded.
- out_ready while out_valid is low: ignored.
- Arithmetic: unsigned, no saturation. ACC_WIDTH guarantees no wrap for NUM_TERMS products of all-ones.
- Reset during HOLD or mid-sum: result and partial sum are lost with no output pulse.

Decomposition:
- Package mult_accum_pkg holds:
  - state enum typedef {ACC, HOLD};
  - function computing ACC_WIDTH from WIDTH and NUM_TERMS, so `mult`-side users can size their sinks.
- No sub-module: datapath is a single adder plus counter.

Test Plan:
- Basic sum: after reset, drive products 3,5,7,9 on consecutive cycles with out_ready=1.
  - out_valid high exactly one cycle after the 4th accept, out_sum = 24.
  - in_ready low for that cycle, then high.
- Max values: four beats of 0xFFFFFFFF -> out_sum = 0x3_FFFF_FFFC; no wrap.
- Backpressure: hold out_ready=0 for 5 cycles after a result.
  - out_valid and out_sum stable for all 5 cycles; in_ready=0.
  - Raising out_ready releases the result; a fresh sum of 1,1,1,1 then gives 4.
- Bubbles: products 10,20,30,40 with in_valid low between every beat -> out_sum = 100; term_cnt steps 0,1,2,3.
- Clear mid-sum: accept 100 and 200, pulse clear, then send 1,2,3,4.
  - out_sum = 10; a beat presented on the clear cycle is not counted.
- Async reset: drop rst_n in HOLD (out_sum=24) mid-cycle.
  - out_valid and out_sum go to 0 before the next edge; after release, the next 4 beats of 2 give 8.

Source files
------------

// File: rtl/mult_accum_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mult_accum_pkg : shared types and sizing helper for the mult_accum block
// Rev 1.0
// ----------------------------------------------------------------------------
package mult_accum_pkg;

  typedef enum logic [0:0] {
    ACC  = 1'b0,
    HOLD = 1'b1
  } acc_state_e;

  // Result width that cannot wrap for num_terms all-ones products.
  function automatic int acc_width(input int width, input int num_terms);
    return width + $clog2(num_terms) + 1;
  endfunction

endpackage : mult_accum_pkg
`default_nettype wire

// File: rtl/mult_accum.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mult_accum : sums NUM_TERMS products per result, registered valid/ready out
// Rev 1.0
// ----------------------------------------------------------------------------
module mult_accum
  import mult_accum_pkg::*;
#(
  parameter  int WIDTH     = 32,
  parameter  int NUM_TERMS = 4,
  localparam int ACC_WIDTH = acc_width(WIDTH, NUM_TERMS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_sum,
  output logic [7:0]           term_cnt
);

  localparam logic [7:0] LAST_TERM = 8'(NUM_TERMS - 1);

  acc_state_e           state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH-1:0] sum_q, sum_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [ACC_WIDTH-1:0] acc_plus_in;

  assign acc_plus_in = acc_q + {{(ACC_WIDTH-WIDTH){1'b0}}, in_data};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    if (clear) begin
      // A beat presented alongside clear is dropped; sum_q is left as-is.
      state_d = ACC;
      acc_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ACC: begin
          if (in_valid) begin
            if (cnt_q == LAST_TERM) begin
              sum_d   = acc_plus_in;
              acc_d   = '0;
              cnt_d   = '0;
              state_d = HOLD;
            end else begin
              acc_d = acc_plus_in;
              cnt_d = cnt_q + 8'd1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_d = ACC;
          end
        end
        default: state_d = ACC;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACC;
      acc_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == ACC);
  assign out_valid = (state_q == HOLD);
  assign out_sum   = sum_q;
  assign term_cnt  = cnt_q;

endmodule : mult_accum
`default_nettype wire

// File: tb/tb_mult_accum.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mult_accum : directed + randomized checks against a queue-based model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_mult_accum;

  localparam int WIDTH     = 32;
  localparam int NUM_TERMS = 4;
  localparam int ACC_WIDTH = WIDTH + $clog2(NUM_TERMS) + 1;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 clear;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] out_sum;
  logic [7:0]           term_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: products accepted so far, and an optional completed result.
  longint unsigned m_terms[$];
  bit              m_pend;
  longint unsigned m_sum;

  mult_accum #(.WIDTH(WIDTH), .NUM_TERMS(NUM_TERMS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .term_cnt  (term_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input longint unsigned got, input longint unsigned exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_terms.delete();
    m_pend = 1'b0;
  endtask

  task automatic model_edge(input bit v, input longint unsigned d, input bit ordy, input bit clr);
    longint unsigned s;
    if (clr) begin
      m_terms.delete();
      m_pend = 1'b0;
    end else if (m_pend) begin
      if (ordy) m_pend = 1'b0;
    end else if (v) begin
      m_terms.push_back(d);
      if (m_terms.size() == NUM_TERMS) begin
        s = 0;
        foreach (m_terms[i]) s += m_terms[i];
        m_sum  = s;
        m_pend = 1'b1;
        m_terms.delete();
      end
    end
  endtask

  task automatic check_outputs();
    check_eq("in_ready", longint'(in_ready), longint'(!m_pend));
    check_eq("out_valid", longint'(out_valid), longint'(m_pend));
    if (m_pend) check_eq("out_sum", longint'(out_sum), m_sum);
    check_eq("term_cnt", longint'(term_cnt), longint'(m_terms.size()));
  endtask

  // One clock: drive inputs, update model at the edge, check at the negedge.
  task automatic cycle(input bit v, input logic [WIDTH-1:0] d, input bit ordy, input bit clr);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    clear     = clr;
    @(posedge clk);
    model_edge(v, longint'(d), ordy, clr);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #2;
    check_eq("rst_out_valid", longint'(out_valid), 0);
    check_eq("rst_out_sum", longint'(out_sum), 0);
    check_eq("rst_term_cnt", longint'(term_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    model_reset();
    apply_reset();

    // Basic sum 3+5+7+9
    cycle(1, 3, 1, 0);
    cycle(1, 5, 1, 0);
    cycle(1, 7, 1, 0);
    cycle(1, 9, 1, 0);
    check_eq("basic_sum", longint'(out_sum), 24);
    check_eq("basic_valid", longint'(out_valid), 1);
    check_eq("basic_in_ready_low", longint'(in_ready), 0);
    cycle(0, 0, 1, 0);
    check_eq("basic_in_ready_back", longint'(in_ready), 1);

    // Max values, then 5 cycles of backpressure with beats offered
    for (int i = 0; i < 4; i++) cycle(1, 32'hFFFF_FFFF, 1, 0);
    check_eq("max_sum", longint'(out_sum), 64'h3_FFFF_FFFC);
    for (int i = 0; i < 5; i++) begin
      cycle(1, 99, 0, 0);
      check_eq("bp_sum_stable", longint'(out_sum), 64'h3_FFFF_FFFC);
      check_eq("bp_valid_stable", longint'(out_valid), 1);
    end
    cycle(0, 0, 1, 0);
    for (int i = 0; i < 4; i++) cycle(1, 1, 1, 0);
    check_eq("ones_sum", longint'(out_sum), 4);
    cycle(0, 0, 1, 0);

    // Bubbles between beats
    for (int i = 1; i <= 4; i++) begin
      check_eq("bubble_cnt", longint'(term_cnt), longint'(i - 1));
      cycle(1, 32'(10 * i), 1, 0);
      if (i < 4) cycle(0, 32'hDEAD, 1, 0);
    end
    check_eq("bubble_sum", longint'(out_sum), 100);
    cycle(0, 0, 1, 0);

    // Clear mid-sum with a beat presented on the clear cycle
    cycle(1, 100, 1, 0);
    cycle(1, 200, 1, 0);
    cycle(1, 500, 1, 1);
    check_eq("clear_cnt", longint'(term_cnt), 0);
    for (int i = 1; i <= 4; i++) cycle(1, 32'(i), 1, 0);
    check_eq("clear_sum", longint'(out_sum), 10);
    cycle(0, 0, 1, 0);

    // Async reset while holding 24
    for (int i = 0; i < 4; i++) cycle(1, 6, 0, 0);
    check_eq("hold_sum", longint'(out_sum), 24);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("async_out_valid", longint'(out_valid), 0);
    check_eq("async_out_sum", longint'(out_sum), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_outputs();
    for (int i = 0; i < 4; i++) cycle(1, 2, 1, 0);
    check_eq("post_reset_sum", longint'(out_sum), 8);
    cycle(0, 0, 1, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [WIDTH-1:0] d;
      d = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
      cycle(bit'($urandom_range(0, 3) != 0), d,
            bit'($urandom_range(0, 1)), bit'($urandom_range(0, 31) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_mult_accum
`default_nettype wire
